// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter
// Two-master arbiter for the 8-bit data-memory bus. Master 0 is the CPU and
// master 1 is a secondary agent such as debug or DMA. The block owns the grant
// FSM, applies round-robin fairness on ties, can insert an optional one-cycle
// turnaround gap, and drives the shared slave-side request bus.
// Once a master owns the bus it is never preempted, so multi-cycle CPU
// sequences such as stack push/pop stay atomic.

module dmem_bus_arbiter #(
    parameter int TURNAROUND = 1,   // 0: edge-to-edge handover, 1: one idle cycle between owners
    parameter int RESET_PRIO = 0    // master that wins the first tie after reset
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       m0_bus_req,
    output logic       m0_bus_grant,
    input  logic [7:0] m0_mst2slv_addr,
    input  logic       m0_mst2slv_wr,
    input  logic       m0_mst2slv_rd,
    input  logic [7:0] m0_mst2slv_data,

    input  logic       m1_bus_req,
    output logic       m1_bus_grant,
    input  logic [7:0] m1_mst2slv_addr,
    input  logic       m1_mst2slv_wr,
    input  logic       m1_mst2slv_rd,
    input  logic [7:0] m1_mst2slv_data,

    output logic [7:0] s_mst2slv_addr,
    output logic       s_mst2slv_wr,
    output logic       s_mst2slv_rd,
    output logic [7:0] s_mst2slv_data,

    output logic [1:0] bus_owner,
    output logic [7:0] arb_conflicts
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10,
        GAP  = 2'b11
    } state_t;

    localparam logic RESET_PTR = (RESET_PRIO != 0) ? 1'b1 : 1'b0;

    state_t     r_state;
    state_t     w_nextState;
    logic       r_ptr;
    logic       w_nextPtr;
    logic       r_grant0;
    logic       r_grant1;
    logic [7:0] r_conflicts;
    logic       w_conflict;

    // Ownership choice from an unowned bus: a lone requester wins outright,
    // a tie goes to the master named by the round-robin pointer.
    function automatic state_t arbitrate(input logic req0, input logic req1, input logic ptr);
        state_t result;
        result = IDLE;
        if (req0 && req1) begin
            result = ptr ? OWN1 : OWN0;
        end else if (req0) begin
            result = OWN0;
        end else if (req1) begin
            result = OWN1;
        end
        return result;
    endfunction

    // Next-state and pointer logic: owners keep the bus while requesting; on
    // release the pointer moves to the other master and either a gap cycle is
    // inserted or the bus is re-arbitrated on the same edge.
    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_ptr;
        case (r_state)
            IDLE, GAP: begin
                w_nextState = arbitrate(m0_bus_req, m1_bus_req, r_ptr);
            end
            OWN0: begin
                if (!m0_bus_req) begin
                    w_nextPtr = 1'b1;
                    if (TURNAROUND != 0) begin
                        w_nextState = GAP;
                    end else begin
                        w_nextState = arbitrate(m0_bus_req, m1_bus_req, 1'b1);
                    end
                end
            end
            OWN1: begin
                if (!m1_bus_req) begin
                    w_nextPtr = 1'b0;
                    if (TURNAROUND != 0) begin
                        w_nextState = GAP;
                    end else begin
                        w_nextState = arbitrate(m0_bus_req, m1_bus_req, 1'b0);
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, pointer and registered grants; reset drops grants immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_ptr    <= RESET_PTR;
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_ptr    <= w_nextPtr;
            r_grant0 <= (w_nextState == OWN0);
            r_grant1 <= (w_nextState == OWN1);
        end
    end

    // A conflict cycle is one where both masters want the bus but at most one holds it.
    assign w_conflict = m0_bus_req && m1_bus_req &&
                        ((!r_grant0 && !r_grant1) || (r_grant0 != r_grant1));

    // Saturating conflict counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_conflicts <= 8'd0;
        end else if (w_conflict && (r_conflicts != 8'hFF)) begin
            r_conflicts <= r_conflicts + 8'd1;
        end
    end

    assign m0_bus_grant  = r_grant0;
    assign m1_bus_grant  = r_grant1;
    assign bus_owner     = {r_grant1, r_grant0};
    assign arb_conflicts = r_conflicts;

    // Slave bus: each master's fields are masked by its own grant, so a
    // non-granted master can never leak strobes or data onto the bus.
    assign s_mst2slv_addr = ({8{r_grant0}} & m0_mst2slv_addr) | ({8{r_grant1}} & m1_mst2slv_addr);
    assign s_mst2slv_data = ({8{r_grant0}} & m0_mst2slv_data) | ({8{r_grant1}} & m1_mst2slv_data);
    assign s_mst2slv_wr   = (r_grant0 & m0_mst2slv_wr) | (r_grant1 & m1_mst2slv_wr);
    assign s_mst2slv_rd   = (r_grant0 & m0_mst2slv_rd) | (r_grant1 & m1_mst2slv_rd);

    grantsExclusive: assert property (@(posedge clk) disable iff (!rst) !(r_grant0 && r_grant1));

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Two-master arbiter for the 8-bit data-memory bus. It sits directly upstream of the CPU master port and produces the bus grant that port consumes.
- Master 0 is the MiniRISC CPU (bus_req/bus_grant, mst2slv addr/wr/rd/data). Master 1 is a second agent, such as the debug or DMA unit.
- The block owns the grant state machine, applies round-robin fairness and an optional turnaround cycle, and drives the shared slave-side bus.
- Read data (slv2mst) is fanned out outside this block.

Parameters:
- TURNAROUND, 1, number of idle cycles inserted between two ownerships. Legal values: 0 or 1.
- RESET_PRIO, 0, master index that wins the first tie after reset.

Ports:
- clk  input  1  system clock
- rst  input  1  reset. One clock; reset is asynchronous and active-low (rst=0 resets).
- m0_bus_req  input  1  master 0 request (CPU)
- m0_bus_grant  output  1  master 0 grant
- m0_mst2slv_addr  input  8  master 0 address
- m0_mst2slv_wr  input  1  master 0 write strobe
- m0_mst2slv_rd  input  1  master 0 read strobe
- m0_mst2slv_data  input  8  master 0 write data
- m1_bus_req, m1_bus_grant, m1_mst2slv_addr, m1_mst2slv_wr, m1_mst2slv_rd, m1_mst2slv_data  same as master 0, for master 1
- s_mst2slv_addr  output  8  shared slave address
- s_mst2slv_wr  output  1  shared write strobe
- s_mst2slv_rd  output  1  shared read strobe
- s_mst2slv_data  output  8  shared write data
- bus_owner  output  2  owner: 00 none, 01 m0, 10 m1
- arb_conflicts  output  8  saturating count of cycles in which both masters request while neither or only one is granted

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, both grants=0, bus_owner=00.
  - All s_* outputs=0, arb_conflicts=0.
  - Round-robin pointer set to RESET_PRIO.
- States: IDLE, OWN0, OWN1, GAP.
- Grants and bus_owner are registered: grant rises one clk after the request is sampled high in IDLE.
- IDLE transitions:
  - Only req0 high -> OWN0.
  - Only req1 high -> OWN1.
  - Both high -> the master named by the pointer wins.
  - Neither high -> stay in IDLE.
- OWNk, reqk high: stay. Ownership is never preempted, so multi-cycle CPU stack push/pop sequences stay atomic.
- OWNk, reqk low at a clock edge:
  - Pointer is set to the other master.
  - TURNAROUND=1 -> GAP. Grant drops on that edge.
  - TURNAROUND=0 -> arbitrate immediately using IDLE rules with the updated pointer. Ownership can hand over edge-to-edge with no idle cycle.
- GAP: lasts exactly one cycle with no grant, then arbitrates using IDLE rules.
- Slave bus (combinational):
  - s_* = (m0 fields AND m0_bus_grant) OR (m1 fields AND m1_bus_grant).
  - Strobes or data driven by a non-granted master never reach the slave.
- The two grants are never high in the same cycle. This is an invariant, checked by assertion.
- arb_conflicts increments on every cycle where req0 & req1 are high and bus_owner is 00, or where exactly one of the requesters owns the bus. It saturates at 255.
- Reset asserted mid-ownership: grants drop asynchronously, the slave strobes go to 0 in the same cycle, and the pointer returns to RESET_PRIO.
- A req pulse of one cycle in IDLE still yields a one-cycle grant. Dropping the request during that grant then follows the normal OWNk release rule.

Test Plan:
- Reset: hold rst=0 with both reqs high -> grants 0, s_* 0, bus_owner 00. Release rst -> next edge m0_bus_grant=1 (RESET_PRIO=0).
- Single master: req1=1 for 5 cycles with addr 0x3C, wr=1, data 0xA5 -> grant1 high 5 cycles from the cycle after the request; s_addr=0x3C, s_wr=1, s_data=0xA5 during the grant; all 0 after release.
- Fairness: both reqs held high and each releases after 3 granted cycles, TURNAROUND=1 -> ownership sequence m0(3), gap(1), m1(3), gap(1), m0. arb_conflicts increments every cycle.
- No preemption: m0 holds req for 20 cycles while req1 is high throughout -> m1 never granted until m0 releases; grant1 never overlaps grant0.
- Gating: m1 drives wr=1, addr 0xFF while not granted and m0 owns the bus with rd=1, addr 0x10 -> s_wr=0, s_rd=1, s_addr=0x10.
- TURNAROUND=0 and async reset: with TURNAROUND=0, m0 releases while req1 is high -> grant1 rises on the same edge grant0 falls. Then assert rst mid-ownership -> grant1=0 immediately and arb_conflicts=0.
